uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
Single-clock, parametrised UART transceiver: the next generation of the team's UART top. It generalises data width, stop-bit count and bit timing, and replaces the separate TX/RX clocks with per-direction baud dividers driven from one system clock. TX uses a valid/ready handshake. RX oversamples with 3-sample majority voting. It sits between the system bus logic and the serial pins.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal 5..9.
PRESCALE_WIDTH, 6, width of the oversampling-ratio input.
DIV_WIDTH, 16, width of the baud divider input.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
BAUD_DIV  in  DIV_WIDTH  oversample tick every BAUD_DIV+1 clocks.
PRESCALE  in  PRESCALE_WIDTH  oversample ticks per bit; legal even values 4..max.
PAR_EN  in  1  1 = parity bit present.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
STOP2  in  1  0 = one stop bit, 1 = two stop bits.
TX_DATA  in  DATA_WIDTH  word to transmit.
TX_VALID  in  1  TX request.
TX_READY  out  1  TX can accept a word.
TX_OUT  out  1  serial output; idle high.
TX_BUSY  out  1  frame in progress.
RX_IN  in  1  asynchronous serial input.
RX_DATA  out  DATA_WIDTH  last received word.
RX_VALID  out  1  one-cycle pulse per completed frame.
PAR_ERR  out  1  parity mismatch on the frame flagged by RX_VALID.
STP_ERR  out  1  a stop bit sampled 0 on the frame flagged by RX_VALID.

Behaviour:
- Clock/reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: TX_OUT=1, TX_READY=1, TX_BUSY=0, RX_DATA=0, RX_VALID=0, PAR_ERR=0, STP_ERR=0. Both FSMs go to IDLE. Dividers and counters clear.
- Reset mid-frame: the frame is abandoned. TX_OUT=1 on the edge where RST is sampled. No RX_VALID is produced.
- Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits(1). Parity is XOR of the data, inverted when PAR_TYP=1.
- Config latching: BAUD_DIV, PRESCALE, PAR_EN, PAR_TYP and STOP2 are latched at TX acceptance (TX side) and at start-edge detection (RX side). Mid-frame changes are ignored.
- Bit period: exactly (BAUD_DIV+1)*PRESCALE clocks. Each direction has its own divider, restarted at frame start.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped if PAR_EN=0) -> STOP -> IDLE.
  - TX_READY=1 only in IDLE, and TX_BUSY = !TX_READY.
  - Accept on TX_VALID & TX_READY: latch TX_DATA; TX_OUT=0 from the next cycle.
  - TX_VALID while busy is ignored.
  - After the final stop bit completes, TX_READY=1 in that same next cycle. Back-to-back frames have no idle gap beyond the stop bits.
- RX input path: RX_IN passes a 2-flop synchroniser (2-cycle latency).
- RX FSM states: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: a falling edge on the synchronised input starts the RX divider.
  - Sampling: each bit is majority-voted over samples at oversample ticks PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - START voted 1: false start; return to IDLE, no output.
  - With STOP2=1, both stop bits are checked; either bit sampled 0 sets STP_ERR.
  - On the final stop vote, the next cycle sets RX_VALID=1 for exactly one cycle, with RX_DATA, PAR_ERR and STP_ERR updated together. These outputs hold until the next frame.
  - The FSM returns to IDLE immediately after the final stop vote, so it is ready for the next start edge mid stop bit.
- Counters: the TX/RX bit-index counter is width clog2(DATA_WIDTH+1). The oversample counter is PRESCALE_WIDTH wide and wraps at PRESCALE-1 to 0.
- Error frames: RX_VALID still pulses; the flags qualify the data.

Optional Feature:
UART_LOOPBACK_EN:
- Defined: adds input port LOOPBACK (1 bit).
  - LOOPBACK=1: RX takes the internal TX serial stream directly, bypassing the synchroniser, and TX_OUT is held 1.
  - LOOPBACK=0: normal operation.
- Undefined: no LOOPBACK port; RX is always fed from synchronised RX_IN.

Test Plan:
1. DATA_WIDTH=8, BAUD_DIV=0, PRESCALE=8, PAR_EN=0, STOP2=0; send 0xA5 -> TX_OUT=0,1,0,1,0,0,1,0,1,1, each bit 8 clocks. TX_READY low for 80 clocks. A looped RX gives RX_VALID with RX_DATA=0xA5 and no errors.
2. PAR_EN=1, PAR_TYP=1, STOP2=1, BAUD_DIV=3, PRESCALE=16; send 0x0F -> parity bit=1, two stop bits, frame=12*64=768 clocks. RX_DATA=0x0F.
3. RX frame 0x3C with the parity bit flipped -> RX_VALID pulse with PAR_ERR=1 and RX_DATA=0x3C. Then a frame with the second stop bit 0 (STOP2=1) -> STP_ERR=1.
4. RX_IN low for 2 clocks only (PRESCALE=8, BAUD_DIV=0) -> no RX_VALID; RX FSM back in IDLE. Then a valid frame 0x55 -> RX_VALID.
5. Assert RST mid-DATA of TX frame 0xFF -> TX_OUT=1, TX_READY=1 next cycle. The following frame 0x81 transmits correctly.
6. (UART_LOOPBACK_EN) LOOPBACK=1; send 0x7E -> TX_OUT stays 1 and RX_DATA=0x7E.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param: single-clock UART transceiver with per-direction baud dividers and 3-sample RX voting.
// Optional `UART_LOOPBACK_EN adds a LOOPBACK port that feeds RX from the internal TX stream.
`timescale 1ns/1ps
module uart_core_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DIV_WIDTH-1:0]      BAUD_DIV,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [DATA_WIDTH-1:0]     TX_DATA,
  input  logic                      TX_VALID,
  output logic                      TX_READY,
  output logic                      TX_OUT,
  output logic                      TX_BUSY,
  input  logic                      RX_IN,
  output logic [DATA_WIDTH-1:0]     RX_DATA,
  output logic                      RX_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                      LOOPBACK
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX ----------------
  state_t                    tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0]      tx_div_q, tx_div_d;
  logic [PRESCALE_WIDTH-1:0] tx_pre_q, tx_pre_d;
  logic                      tx_par_en_q, tx_par_en_d;
  logic                      tx_stop2_q, tx_stop2_d;
  logic                      tx_par_bit_q, tx_par_bit_d;
  logic [DATA_WIDTH-1:0]     tx_shift_q, tx_shift_d;
  logic [DIV_WIDTH-1:0]      tx_dcnt_q, tx_dcnt_d;
  logic [PRESCALE_WIDTH-1:0] tx_os_q, tx_os_d;
  logic [CW-1:0]             tx_bit_q, tx_bit_d;
  logic                      tx_out_q, tx_out_d;
  logic                      tx_tick, tx_bit_end;

  assign tx_tick    = (tx_dcnt_q == tx_div_q);
  assign tx_bit_end = tx_tick && (tx_os_q == tx_pre_q - PRESCALE_WIDTH'(1));

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_div_d     = tx_div_q;
    tx_pre_d     = tx_pre_q;
    tx_par_en_d  = tx_par_en_q;
    tx_stop2_d   = tx_stop2_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_dcnt_d    = tx_dcnt_q;
    tx_os_d      = tx_os_q;
    tx_bit_d     = tx_bit_q;
    tx_out_d     = tx_out_q;

    if (tx_state_q != S_IDLE) begin
      if (tx_tick) begin
        tx_dcnt_d = '0;
        tx_os_d   = tx_bit_end ? '0 : tx_os_q + PRESCALE_WIDTH'(1);
      end else begin
        tx_dcnt_d = tx_dcnt_q + DIV_WIDTH'(1);
      end
    end

    case (tx_state_q)
      S_IDLE: begin
        if (TX_VALID) begin
          tx_div_d     = BAUD_DIV;
          tx_pre_d     = PRESCALE;
          tx_par_en_d  = PAR_EN;
          tx_stop2_d   = STOP2;
          tx_par_bit_d = (^TX_DATA) ^ PAR_TYP;
          tx_shift_d   = TX_DATA;
          tx_dcnt_d    = '0;
          tx_os_d      = '0;
          tx_bit_d     = '0;
          tx_out_d     = 1'b0;
          tx_state_d   = S_START;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_out_d   = tx_shift_q[0];
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == LAST_BIT) begin
            tx_bit_d = '0;
            if (tx_par_en_q) begin
              tx_out_d   = tx_par_bit_q;
              tx_state_d = S_PARITY;
            end else begin
              tx_out_d   = 1'b1;
              tx_state_d = S_STOP;
            end
          end else begin
            tx_bit_d   = tx_bit_q + CW'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_out_d   = tx_shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tx_bit_end) begin
          tx_out_d   = 1'b1;
          tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          if (!tx_stop2_q || tx_bit_q == CW'(1)) begin
            tx_state_d = S_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + CW'(1);
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q   <= S_IDLE;
      tx_div_q     <= '0;
      tx_pre_q     <= '0;
      tx_par_en_q  <= 1'b0;
      tx_stop2_q   <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_shift_q   <= '0;
      tx_dcnt_q    <= '0;
      tx_os_q      <= '0;
      tx_bit_q     <= '0;
      tx_out_q     <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_div_q     <= tx_div_d;
      tx_pre_q     <= tx_pre_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_stop2_q   <= tx_stop2_d;
      tx_par_bit_q <= tx_par_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_dcnt_q    <= tx_dcnt_d;
      tx_os_q      <= tx_os_d;
      tx_bit_q     <= tx_bit_d;
      tx_out_q     <= tx_out_d;
    end
  end

  assign TX_READY = (tx_state_q == S_IDLE);
  assign TX_BUSY  = !TX_READY;

  // ---------------- RX ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_line;

`ifdef UART_LOOPBACK_EN
  assign TX_OUT  = LOOPBACK ? 1'b1 : tx_out_q;
  assign rx_line = LOOPBACK ? tx_out_q : rx_s2_q;
`else
  assign TX_OUT  = tx_out_q;
  assign rx_line = rx_s2_q;
`endif

  state_t                    rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0]      rx_div_q, rx_div_d;
  logic [PRESCALE_WIDTH-1:0] rx_pre_q, rx_pre_d;
  logic                      rx_par_en_q, rx_par_en_d;
  logic                      rx_par_typ_q, rx_par_typ_d;
  logic                      rx_stop2_q, rx_stop2_d;
  logic [DIV_WIDTH-1:0]      rx_dcnt_q, rx_dcnt_d;
  logic [PRESCALE_WIDTH-1:0] rx_os_q, rx_os_d;
  logic [CW-1:0]             rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0]     rx_shift_q, rx_shift_d;
  logic [1:0]                rx_smp_q, rx_smp_d;
  logic                      rx_par_q, rx_par_d;
  logic                      rx_stp_q, rx_stp_d;
  logic [DATA_WIDTH-1:0]     rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;

  logic                      rx_tick, rx_bit_end, rx_vote, rx_vote_now, rx_final, rx_stp_acc;
  logic [PRESCALE_WIDTH-1:0] rx_half, rx_v0, rx_v2;

  // Three samples straddle the bit centre; the third is taken live at the vote tick.
  assign rx_half     = {1'b0, rx_pre_q[PRESCALE_WIDTH-1:1]};
  assign rx_v0       = rx_half - PRESCALE_WIDTH'(1);
  assign rx_v2       = rx_half + PRESCALE_WIDTH'(1);
  assign rx_tick     = (rx_dcnt_q == rx_div_q);
  assign rx_bit_end  = rx_tick && (rx_os_q == rx_pre_q - PRESCALE_WIDTH'(1));
  assign rx_vote     = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_line) | (rx_smp_q[1] & rx_line);
  assign rx_vote_now = (rx_state_q != S_IDLE) && rx_tick && (rx_os_q == rx_v2);
  assign rx_final    = rx_vote_now && (!rx_stop2_q || rx_bit_q == CW'(1));
  assign rx_stp_acc  = rx_stp_q | ~rx_vote;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_div_d     = rx_div_q;
    rx_pre_d     = rx_pre_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_typ_d = rx_par_typ_q;
    rx_stop2_d   = rx_stop2_q;
    rx_dcnt_d    = rx_dcnt_q;
    rx_os_d      = rx_os_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_smp_d     = rx_smp_q;
    rx_par_d     = rx_par_q;
    rx_stp_d     = rx_stp_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;

    if (rx_state_q != S_IDLE) begin
      if (rx_tick) begin
        rx_dcnt_d = '0;
        rx_os_d   = rx_bit_end ? '0 : rx_os_q + PRESCALE_WIDTH'(1);
        if (rx_os_q == rx_v0) rx_smp_d[0] = rx_line;
        if (rx_os_q == rx_half) rx_smp_d[1] = rx_line;
      end else begin
        rx_dcnt_d = rx_dcnt_q + DIV_WIDTH'(1);
      end
    end

    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_line) begin
          rx_div_d     = BAUD_DIV;
          rx_pre_d     = PRESCALE;
          rx_par_en_d  = PAR_EN;
          rx_par_typ_d = PAR_TYP;
          rx_stop2_d   = STOP2;
          rx_dcnt_d    = '0;
          rx_os_d      = '0;
          rx_bit_d     = '0;
          rx_stp_d     = 1'b0;
          rx_state_d   = S_START;
        end
      end
      S_START: begin
        if (rx_vote_now && rx_vote) rx_state_d = S_IDLE;
        else if (rx_bit_end) rx_state_d = S_DATA;
      end
      S_DATA: begin
        if (rx_vote_now) rx_shift_d = {rx_vote, rx_shift_q[DATA_WIDTH-1:1]};
        if (rx_bit_end) begin
          if (rx_bit_q == LAST_BIT) begin
            rx_bit_d   = '0;
            rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + CW'(1);
          end
        end
      end
      S_PARITY: begin
        if (rx_vote_now) rx_par_d = rx_vote;
        if (rx_bit_end) rx_state_d = S_STOP;
      end
      S_STOP: begin
        if (rx_final) begin
          rx_state_d = S_IDLE;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          par_err_d  = rx_par_en_q && (rx_par_q != ((^rx_shift_q) ^ rx_par_typ_q));
          stp_err_d  = rx_stp_acc;
        end else begin
          if (rx_vote_now) rx_stp_d = rx_stp_acc;
          if (rx_bit_end) rx_bit_d = rx_bit_q + CW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_div_q     <= '0;
      rx_pre_q     <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_typ_q <= 1'b0;
      rx_stop2_q   <= 1'b0;
      rx_dcnt_q    <= '0;
      rx_os_q      <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_smp_q     <= '0;
      rx_par_q     <= 1'b0;
      rx_stp_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      rx_s1_q      <= RX_IN;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_line;
      rx_state_q   <= rx_state_d;
      rx_div_q     <= rx_div_d;
      rx_pre_q     <= rx_pre_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_typ_q <= rx_par_typ_d;
      rx_stop2_q   <= rx_stop2_d;
      rx_dcnt_q    <= rx_dcnt_d;
      rx_os_q      <= rx_os_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_smp_q     <= rx_smp_d;
      rx_par_q     <= rx_par_d;
      rx_stp_q     <= rx_stp_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign PAR_ERR  = par_err_q;
  assign STP_ERR  = stp_err_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed self-checking bench for uart_core_param: TX frame shapes, looped/driven RX frames, errors, reset.
`timescale 1ns/1ps
module tb_uart_core_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = '0;
  logic [5:0]  prescale = 6'd8;
  logic        par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        rx_drv = 1'b1, loop_ext = 1'b0;
  wire         tx_ready, tx_out, tx_busy, rx_in;
  wire  [7:0]  rx_data;
  wire         rx_valid, par_err, stp_err;
`ifdef UART_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif

  assign rx_in = loop_ext ? tx_out : rx_drv;

  uart_core_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .DIV_WIDTH(16)) dut (
    .CLK(clk), .RST(rst), .BAUD_DIV(baud_div), .PRESCALE(prescale),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .TX_OUT(tx_out), .TX_BUSY(tx_busy), .RX_IN(rx_in),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .PAR_ERR(par_err), .STP_ERR(stp_err)
`ifdef UART_LOOPBACK_EN
    , .LOOPBACK(loopback)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int rx_cnt = 0;
  logic [7:0] cap_data = '0;
  logic cap_par = 1'b0, cap_stp = 1'b0;

  // Every RX_VALID cycle is counted, so a stretched pulse shows up as an extra frame.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt   <= rx_cnt + 1;
      cap_data <= rx_data;
      cap_par  <= par_err;
      cap_stp  <= stp_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    chk("tx_ready_before_accept", 32'(tx_ready), 1);
    tick(1);
    tx_valid = 1'b0;
    chk("tx_busy_after_accept", 32'(tx_busy), 1);
  endtask

  // frame[0] is the first bit on the wire; forced_high expects TX_OUT parked at 1.
  task automatic check_tx(input string tag, input logic [11:0] frame, input int nbits,
                          input int bitlen, input logic forced_high);
    logic expb;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < bitlen; c++) begin
        expb = forced_high ? 1'b1 : frame[b];
        chk({tag, "_tx_out"}, 32'(tx_out), 32'(expb));
        chk({tag, "_tx_ready_low"}, 32'(tx_ready), 0);
        tick(1);
      end
    end
    chk({tag, "_tx_ready_end"}, 32'(tx_ready), 1);
    chk({tag, "_tx_out_idle"}, 32'(tx_out), 1);
    $display("tx frame %s: %0d bits x %0d clocks done", tag, nbits, bitlen);
  endtask

  task automatic rx_send(input logic [11:0] frame, input int nbits, input int bitlen);
    for (int b = 0; b < nbits; b++) begin
      rx_drv = frame[b];
      tick(bitlen);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input string tag, input int exp_cnt, input int budget);
    int n = 0;
    while (rx_cnt < exp_cnt && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, rx_cnt, exp_cnt);
    $display("rx frame %s: data=%02h par_err=%0b stp_err=%0b", tag, cap_data, cap_par, cap_stp);
  endtask

  initial begin
    tick(3);
    chk("rst_tx_out", 32'(tx_out), 1);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_par_err", 32'(par_err), 0);
    chk("rst_stp_err", 32'(stp_err), 0);
    rst = 1'b0;
    tick(2);

    // 1: 0xA5, 8N1, 8 clocks/bit, looped back externally
    loop_ext = 1'b1;
    start_tx(8'hA5);
    check_tx("t1", 12'h34A, 10, 8, 1'b0);
    wait_rx("t1_rx_count", 1, 200);
    chk("t1_rx_data", 32'(cap_data), 'hA5);
    chk("t1_par_err", 32'(cap_par), 0);
    chk("t1_stp_err", 32'(cap_stp), 0);

    // 2: 0x0F, odd parity, two stops, 64 clocks/bit
    baud_div = 16'd3; prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
    tick(2);
    start_tx(8'h0F);
    check_tx("t2", 12'hE1E, 12, 64, 1'b0);
    wait_rx("t2_rx_count", 2, 300);
    chk("t2_rx_data", 32'(cap_data), 'h0F);
    chk("t2_par_err", 32'(cap_par), 0);
    chk("t2_stp_err", 32'(cap_stp), 0);

    // 3: driven RX frames, even parity, two stops: bad parity, then second stop low
    loop_ext = 1'b0; rx_drv = 1'b1;
    baud_div = 16'd0; prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1;
    tick(4);
    rx_send(12'hE78, 12, 8);
    wait_rx("t3a_rx_count", 3, 40);
    chk("t3a_rx_data", 32'(cap_data), 'h3C);
    chk("t3a_par_err", 32'(cap_par), 1);
    chk("t3a_stp_err", 32'(cap_stp), 0);
    rx_send(12'h478, 12, 8);
    wait_rx("t3b_rx_count", 4, 40);
    chk("t3b_rx_data", 32'(cap_data), 'h3C);
    chk("t3b_par_err", 32'(cap_par), 0);
    chk("t3b_stp_err", 32'(cap_stp), 1);

    // 4: 2-clock glitch is a false start, then a good 0x55 frame
    par_en = 1'b0; stop2 = 1'b0;
    tick(10);
    rx_drv = 1'b0;
    tick(2);
    rx_drv = 1'b1;
    tick(30);
    chk("t4_glitch_no_valid", rx_cnt, 4);
    chk("t4_rx_data_held", 32'(rx_data), 'h3C);
    rx_send(12'h2AA, 10, 8);
    wait_rx("t4_rx_count", 5, 40);
    chk("t4_rx_data", 32'(cap_data), 'h55);
    chk("t4_par_err", 32'(cap_par), 0);
    chk("t4_stp_err", 32'(cap_stp), 0);

    // 5: reset in the middle of 0xFF, then 0x81 goes out intact
    loop_ext = 1'b1;
    tick(4);
    start_tx(8'hFF);
    tick(30);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_tx_out", 32'(tx_out), 1);
    chk("t5_rst_tx_ready", 32'(tx_ready), 1);
    chk("t5_rst_rx_data", 32'(rx_data), 0);
    rst = 1'b0;
    tick(30);
    chk("t5_abandoned_no_rx", rx_cnt, 5);
    start_tx(8'h81);
    check_tx("t5", 12'h302, 10, 8, 1'b0);
    wait_rx("t5_rx_count", 6, 100);
    chk("t5_rx_data", 32'(cap_data), 'h81);
    chk("t5_stp_err", 32'(cap_stp), 0);

`ifdef UART_LOOPBACK_EN
    // 6: internal loopback keeps the pin high and still receives 0x7E
    loop_ext = 1'b0; rx_drv = 1'b1; loopback = 1'b1;
    tick(4);
    start_tx(8'h7E);
    check_tx("t6", 12'h000, 10, 8, 1'b1);
    wait_rx("t6_rx_count", 7, 100);
    chk("t6_rx_data", 32'(cap_data), 'h7E);
    loopback = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
